load_buffer_tracker: RTL and testbench

//  Tracks outstanding data-cache loads issued by the load unit, sized by NrLoadBufEntries.
//  On issue it allocates a tag (buffer index) and records trans-id, byte offset, size and sign.
//  On the cache response it extracts, aligns and extends the load data, then returns it registered.

---
 rtl/load_buffer_tracker.sv | 178 +++++++++++++++++
 tb/tb_load_buffer_tracker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_buffer_tracker.sv
// Tracks outstanding data-cache loads: allocates a tag per issued load, keeps its
// trans-id/offset/size/sign, and on the cache response returns aligned, extended data.
module load_buffer_tracker #(
    parameter int NR_ENTRIES = 2,
    parameter int TRANS_ID_W = 3,
    parameter int XLEN       = 64,
    parameter int TAG_W      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1,
    parameter int OFF_W      = $clog2(XLEN / 8)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [TRANS_ID_W-1:0] req_trans_id_i,
    input  logic [OFF_W-1:0]      req_offset_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    output logic [TAG_W-1:0]      req_tag_o,
    input  logic                  rsp_valid_i,
    input  logic [TAG_W-1:0]      rsp_tag_i,
    input  logic [XLEN-1:0]       rsp_data_i,
    output logic                  result_valid_o,
    output logic [TRANS_ID_W-1:0] result_trans_id_o,
    output logic [XLEN-1:0]       result_data_o,
    output logic                  spurious_o,
    output logic                  empty_o
);
    localparam int IDX_W = $clog2(XLEN);
    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_LIVE   = 2'd1;
    localparam logic [1:0] ST_KILLED = 2'd2;

    logic [NR_ENTRIES-1:0]                 free_vec;
    logic [NR_ENTRIES-1:0]                 live_vec;
    logic [NR_ENTRIES-1:0]                 rsp_hit;
    logic [NR_ENTRIES-1:0]                 alloc_onehot;
    logic [NR_ENTRIES-1:0][TRANS_ID_W-1:0] trans_id_vec;
    logic [NR_ENTRIES-1:0][OFF_W-1:0]      offset_vec;
    logic [NR_ENTRIES-1:0][1:0]            size_vec;
    logic [NR_ENTRIES-1:0]                 sign_vec;

    logic                  handshake;
    logic [TAG_W-1:0]      alloc_tag;
    logic                  rsp_live;
    logic                  rsp_spurious;
    logic [TRANS_ID_W-1:0] sel_trans_id;
    logic [OFF_W-1:0]      sel_offset;
    logic [1:0]            sel_size;
    logic                  sel_sign;
    logic [XLEN-1:0]       shifted;
    logic [IDX_W-1:0]      top_idx;
    logic                  sign_fill;
    logic [XLEN-1:0]       ext_data;

    logic                  result_valid_reg;
    logic [TRANS_ID_W-1:0] result_trans_id_reg;
    logic [XLEN-1:0]       result_data_reg;
    logic                  spurious_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
            logic [1:0]            state_reg;
            logic [1:0]            state_next;
            logic [TRANS_ID_W-1:0] trans_id_reg;
            logic [OFF_W-1:0]      offset_reg;
            logic [1:0]            size_reg;
            logic                  sign_reg;

            assign free_vec[gi]     = (state_reg == ST_FREE);
            assign live_vec[gi]     = (state_reg == ST_LIVE);
            assign rsp_hit[gi]      = rsp_valid_i && (rsp_tag_i == TAG_W'(gi));
            assign alloc_onehot[gi] = handshake && (alloc_tag == TAG_W'(gi));
            assign trans_id_vec[gi] = trans_id_reg;
            assign offset_vec[gi]   = offset_reg;
            assign size_vec[gi]     = size_reg;
            assign sign_vec[gi]     = sign_reg;

            // Allocation only ever targets a FREE entry, so it cannot collide with a
            // response that frees this entry; a flush coinciding with a response frees it.
            always_comb begin
                state_next = state_reg;
                if (alloc_onehot[gi]) begin
                    state_next = ST_LIVE;
                end else if (rsp_hit[gi] && !free_vec[gi]) begin
                    state_next = ST_FREE;
                end else if (flush_i && live_vec[gi]) begin
                    state_next = ST_KILLED;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    state_reg <= ST_FREE;
                end else begin
                    state_reg <= state_next;
                end
                if (alloc_onehot[gi]) begin
                    trans_id_reg <= req_trans_id_i;
                    offset_reg   <= req_offset_i;
                    size_reg     <= req_size_i;
                    sign_reg     <= req_signed_i;
                end
            end
        end
    endgenerate

    always_comb begin
        alloc_tag = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_tag = TAG_W'(i);
            end
        end
    end

    assign req_ready_o = !flush_i && (|free_vec);
    assign handshake   = req_valid_i && req_ready_o;
    assign req_tag_o   = alloc_tag;
    assign empty_o     = &free_vec;

    always_comb begin
        sel_trans_id = '0;
        sel_offset   = '0;
        sel_size     = '0;
        sel_sign     = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (rsp_hit[i]) begin
                sel_trans_id = trans_id_vec[i];
                sel_offset   = offset_vec[i];
                sel_size     = size_vec[i];
                sel_sign     = sign_vec[i];
            end
        end
    end

    assign rsp_live     = |(rsp_hit & live_vec);
    assign rsp_spurious = rsp_valid_i && !(|(rsp_hit & ~free_vec));

    // Bytes shifted past the top of the word read as zero.
    assign shifted = rsp_data_i >> {sel_offset, 3'b000};

    always_comb begin
        case (sel_size)
            2'd0:    top_idx = IDX_W'(7);
            2'd1:    top_idx = IDX_W'(15);
            2'd2:    top_idx = IDX_W'(31);
            default: top_idx = IDX_W'(XLEN - 1);
        endcase
        sign_fill = sel_sign && shifted[top_idx];
        ext_data  = '0;
        for (int i = 0; i < XLEN; i++) begin
            ext_data[i] = (i <= int'(top_idx)) ? shifted[i] : sign_fill;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_valid_reg    <= 1'b0;
            result_trans_id_reg <= '0;
            result_data_reg     <= '0;
            spurious_reg        <= 1'b0;
        end else begin
            result_valid_reg <= rsp_live && !flush_i;
            spurious_reg     <= rsp_spurious;
            if (rsp_live && !flush_i) begin
                result_trans_id_reg <= sel_trans_id;
                result_data_reg     <= ext_data;
            end
        end
    end

    assign result_valid_o    = result_valid_reg;
    assign result_trans_id_o = result_trans_id_reg;
    assign result_data_o     = result_data_reg;
    assign spurious_o        = spurious_reg;
endmodule

// File: tb/tb_load_buffer_tracker.sv
// Scoreboard bench for load_buffer_tracker: a queue-based entry model predicts handshakes,
// tags and results; a separate monitor matches every result/spurious pulse against it.
module tb_load_buffer_tracker;
    localparam int NR = 2;
    localparam int M_FREE = 0, M_LIVE = 1, M_KILLED = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_trans_id_i;
    logic [2:0]  req_offset_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [0:0]  req_tag_o;
    logic        rsp_valid_i;
    logic [0:0]  rsp_tag_i;
    logic [63:0] rsp_data_i;
    logic        result_valid_o;
    logic [2:0]  result_trans_id_o;
    logic [63:0] result_data_o;
    logic        spurious_o;
    logic        empty_o;

    load_buffer_tracker #(.NR_ENTRIES(2), .TRANS_ID_W(3), .XLEN(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_trans_id_i(req_trans_id_i), .req_offset_i(req_offset_i),
        .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_tag_o(req_tag_o),
        .rsp_valid_i(rsp_valid_i), .rsp_tag_i(rsp_tag_i), .rsp_data_i(rsp_data_i),
        .result_valid_o(result_valid_o), .result_trans_id_o(result_trans_id_o),
        .result_data_o(result_data_o), .spurious_o(spurious_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_spur;
        logic [2:0]  id;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    int   m_state [NR];
    int   m_id    [NR];
    int   m_off   [NR];
    int   m_size  [NR];
    bit   m_sign  [NR];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] model_load(logic [63:0] raw, int off, int sz, bit sg);
        logic [63:0] v;
        logic [63:0] mask;
        int          nbits;
        v     = raw >> (off * 8);
        nbits = 8 << sz;
        mask  = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
        v     = v & mask;
        if (sg && (((v >> (nbits - 1)) & 64'd1) != 64'd0)) v = v | ~mask;
        return v;
    endfunction

    function automatic int m_free_count();
        int c = 0;
        for (int i = 0; i < NR; i++) if (m_state[i] == M_FREE) c++;
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < NR; i++) if (m_state[i] == M_FREE) return i;
        return 0;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance the model.
    task automatic step(input bit fl, input bit rv, input int id, input int off, input int sz,
                        input bit sg, input bit rspv, input int rtag, input logic [63:0] rdata);
        bit m_ready;
        int m_tag;
        exp_t e;
        flush_i        = fl;
        req_valid_i    = rv;
        req_trans_id_i = 3'(id);
        req_offset_i   = 3'(off);
        req_size_i     = 2'(sz);
        req_signed_i   = sg;
        rsp_valid_i    = rspv;
        rsp_tag_i      = 1'(rtag);
        rsp_data_i     = rdata;
        @(negedge clk_i);
        m_ready = !fl && (m_free_count() > 0);
        m_tag   = m_lowest_free();
        chk("req_ready", 64'(req_ready_o), 64'(m_ready));
        if (m_ready) chk("req_tag", 64'(req_tag_o), 64'(m_tag));
        chk("empty", 64'(empty_o), 64'(m_free_count() == NR));
        if (rspv) begin
            if (m_state[rtag] == M_FREE) begin
                e.is_spur = 1'b1; e.id = '0; e.data = '0; e.due = cyc + 1;
                exp_q.push_back(e);
            end else begin
                if (m_state[rtag] == M_LIVE && !fl) begin
                    e.is_spur = 1'b0;
                    e.id      = 3'(m_id[rtag]);
                    e.data    = model_load(rdata, m_off[rtag], m_size[rtag], m_sign[rtag]);
                    e.due     = cyc + 1;
                    exp_q.push_back(e);
                end
                m_state[rtag] = M_FREE;
            end
        end
        if (fl) for (int i = 0; i < NR; i++) if (m_state[i] == M_LIVE) m_state[i] = M_KILLED;
        if (rv && m_ready) begin
            m_state[m_tag] = M_LIVE;
            m_id[m_tag]    = id;
            m_off[m_tag]   = off;
            m_size[m_tag]  = sz;
            m_sign[m_tag]  = sg;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 64'd0);
    endtask

    task automatic issue(input int id, input int off, input int sz, input bit sg);
        step(0, 1, id, off, sz, sg, 0, 0, 64'd0);
    endtask

    task automatic respond(input int tag, input logic [63:0] d);
        step(0, 0, 0, 0, 0, 0, 1, tag, d);
    endtask

    // Monitor: every result or spurious pulse must match the oldest expectation due now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    chk("result_valid", 64'(result_valid_o), 64'(!e.is_spur));
                    chk("spurious", 64'(spurious_o), 64'(e.is_spur));
                    if (!e.is_spur) begin
                        chk("result_id", 64'(result_trans_id_o), 64'(e.id));
                        chk("result_data", result_data_o, e.data);
                    end
                end else if (result_valid_o || spurious_o) begin
                    chk("unexpected_output", {62'd0, result_valid_o, spurious_o}, 64'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          fl, rv, sg, rspv;
        int          id, off, sz, rtag;
        logic [63:0] d;

        for (int i = 0; i < NR; i++) m_state[i] = M_FREE;
        rst_ni = 1'b0; flush_i = 0; req_valid_i = 0; req_trans_id_i = 0; req_offset_i = 0;
        req_size_i = 0; req_signed_i = 0; rsp_valid_i = 0; rsp_tag_i = 0; rsp_data_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("reset_empty", 64'(empty_o), 64'd1);
        chk("reset_ready", 64'(req_ready_o), 64'd1);
        chk("reset_tag", 64'(req_tag_o), 64'd0);
        chk("reset_result_valid", 64'(result_valid_o), 64'd0);
        chk("reset_result_data", result_data_o, 64'd0);
        chk("reset_spurious", 64'(spurious_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Sign and zero extension of byte 3
        issue(5, 3, 0, 1);
        respond(0, 64'h0000_0000_8000_0000);
        chk("sext_data", result_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        chk("sext_id", 64'(result_trans_id_o), 64'd5);
        issue(5, 3, 0, 0);
        respond(0, 64'h0000_0000_8000_0000);
        chk("zext_data", result_data_o, 64'h0000_0000_0000_0080);

        // Full, then out-of-order completion
        issue(1, 0, 3, 0);
        issue(2, 0, 3, 0);
        idle();
        respond(1, 64'h1122_3344_5566_7788);
        chk("ooo_first_id", 64'(result_trans_id_o), 64'd2);
        idle();
        respond(0, 64'h8877_6655_4433_2211);
        chk("ooo_second_id", 64'(result_trans_id_o), 64'd1);
        idle();

        // Flush drain: killed entries stay allocated until answered
        issue(3, 0, 2, 1);
        issue(4, 4, 2, 1);
        step(1, 1, 6, 0, 0, 0, 0, 0, 64'd0);
        idle();
        respond(0, 64'hFFFF_FFFF_FFFF_FFFF);
        respond(1, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();

        // Same-cycle issue + response, then flush + response
        issue(3, 0, 1, 1);
        step(0, 1, 4, 2, 1, 0, 1, 0, 64'h0000_0000_CAFE_8001);
        respond(1, 64'h0000_0000_BEEF_0000);
        issue(6, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 64'h55);
        idle();

        // Spurious response to a free tag while tag0 is live
        issue(7, 1, 1, 1);
        respond(1, 64'h1234);
        chk("spurious_pulse", 64'(spurious_o), 64'd1);
        idle();
        chk("spurious_clear", 64'(spurious_o), 64'd0);
        respond(0, 64'h0000_0000_00F0_0000);
        idle();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            fl   = ($urandom_range(15) == 0);
            rv   = $urandom_range(1);
            id   = $urandom_range(7);
            off  = $urandom_range(7);
            sz   = $urandom_range(3);
            sg   = $urandom_range(1);
            rspv = $urandom_range(1);
            rtag = $urandom_range(NR - 1);
            if ($urandom_range(7) != 0) begin
                for (int t = 0; t < NR; t++) if (m_state[t] != M_FREE && $urandom_range(1) == 1) rtag = t;
            end
            d = {$urandom, $urandom};
            step(fl, rv, id, off, sz, sg, rspv, rtag, d);
        end

        for (int t = 0; t < NR; t++) if (m_state[t] != M_FREE) respond(t, {$urandom, $urandom});
        repeat (3) idle();
        chk("drained_empty", 64'(empty_o), 64'd1);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
